// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions for the skid-buffered stage register.
// Control-bit positions and the occupancy state encoding.
package pipe_stage_skid_pkg;

  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_BIT = 1;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  function automatic logic [1:0] occOf(
    input stateT s
  );
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry_reg: enabled payload register, async active-high reset.
// Ports: clk, rst, en, d* payload in, q* payload out; loads on falling edge.
module pipe_entry_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CTRL_W-1:0] dCtrl,
  input  logic [DATA_W-1:0] dData0,
  input  logic [DATA_W-1:0] dData1,
  input  logic [RD_W-1:0]   dRd,
  output logic [CTRL_W-1:0] qCtrl,
  output logic [DATA_W-1:0] qData0,
  output logic [DATA_W-1:0] qData1,
  output logic [RD_W-1:0]   qRd
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      qCtrl  <= '0;
      qData0 <= '0;
      qData1 <= '0;
      qRd    <= '0;
    end else if (en) begin
      qCtrl  <= dCtrl;
      qData0 <= dData0;
      qData1 <= dData1;
      qRd    <= dRd;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage register, falling-edge updated.
// Ports: in_* upstream handshake/payload, out_* head entry, flush, occupancy.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  stateT state;
  stateT nextState;

  logic accept;
  logic consume;
  logic mainEn;
  logic skidEn;
  logic mainFromSkid;

  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData0;
  logic [DATA_W-1:0] mainData1;
  logic [RD_W-1:0]   mainRd;

  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData0;
  logic [DATA_W-1:0] skidData1;
  logic [RD_W-1:0]   skidRd;

  logic [CTRL_W-1:0] mainCtrlD;
  logic [DATA_W-1:0] mainData0D;
  logic [DATA_W-1:0] mainData1D;
  logic [RD_W-1:0]   mainRdD;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    nextState    = state;
    mainEn       = 1'b0;
    skidEn       = 1'b0;
    mainFromSkid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          nextState = ONE;
          mainEn    = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          mainEn = 1'b1;
        end else if (accept) begin
          nextState = FULL;
          skidEn    = 1'b1;
        end else if (consume) begin
          nextState = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          nextState    = ONE;
          mainEn       = 1'b1;
          mainFromSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
    // Flush drops everything; payload regs keep the old head.
    if (flush) begin
      nextState = EMPTY;
      mainEn    = 1'b0;
      skidEn    = 1'b0;
    end
  end

  // Handshake outputs are registered from the next state so
  // out_ready never reaches in_ready combinationally.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= nextState;
      in_ready  <= (nextState != FULL);
      out_valid <= (nextState != EMPTY);
      occupancy <= occOf(nextState);
    end
  end

  always_comb begin
    if (mainFromSkid) begin
      mainCtrlD  = skidCtrl;
      mainData0D = skidData0;
      mainData1D = skidData1;
      mainRdD    = skidRd;
    end else begin
      mainCtrlD  = in_ctrl;
      mainData0D = in_data0;
      mainData1D = in_data1;
      mainRdD    = in_rd;
    end
  end

  pipe_entry_reg #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .CTRL_W(CTRL_W)
  ) mainReg (
    .clk   (clk),
    .rst   (rst),
    .en    (mainEn),
    .dCtrl (mainCtrlD),
    .dData0(mainData0D),
    .dData1(mainData1D),
    .dRd   (mainRdD),
    .qCtrl (mainCtrl),
    .qData0(mainData0),
    .qData1(mainData1),
    .qRd   (mainRd)
  );

  pipe_entry_reg #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .CTRL_W(CTRL_W)
  ) skidReg (
    .clk   (clk),
    .rst   (rst),
    .en    (skidEn),
    .dCtrl (in_ctrl),
    .dData0(in_data0),
    .dData1(in_data1),
    .dRd   (in_rd),
    .qCtrl (skidCtrl),
    .qData0(skidData0),
    .qData1(skidData1),
    .qRd   (skidRd)
  );

  // Writes to x0 are suppressed; nothing leaks while invalid.
  always_comb begin
    out_ctrl = out_valid ? mainCtrl : '0;
    out_ctrl[REGWRITE_BIT] = out_valid
      && mainCtrl[REGWRITE_BIT]
      && (mainRd != '0);
  end

  assign out_data0 = mainData0;
  assign out_data1 = mainData1;
  assign out_rd    = mainRd;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: 32-bit and 64-bit instances share stimulus.
// Queue-based reference model; directed scenarios then random traffic.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [5:0]  rd;
  } entT;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [1:0]  inCtrl;
  logic [63:0] inData0;
  logic [63:0] inData1;
  logic [5:0]  inRd;
  logic        flush;
  logic        outReady;

  logic        aInReady, aOutValid;
  logic [1:0]  aOutCtrl, aOcc;
  logic [31:0] aOutData0, aOutData1;
  logic [4:0]  aOutRd;

  logic        bInReady, bOutValid;
  logic [1:0]  bOutCtrl, bOcc;
  logic [63:0] bOutData0, bOutData1;
  logic [5:0]  bOutRd;

  int checks = 0;
  int errors = 0;

  entT q[$];
  entT lastHead;
  logic [63:0] got[$];
  bit logOn = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dutA (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (aInReady),
    .in_ctrl  (inCtrl),
    .in_data0 (inData0[31:0]),
    .in_data1 (inData1[31:0]),
    .in_rd    (inRd[4:0]),
    .flush    (flush),
    .out_valid(aOutValid),
    .out_ready(outReady),
    .out_ctrl (aOutCtrl),
    .out_data0(aOutData0),
    .out_data1(aOutData1),
    .out_rd   (aOutRd),
    .occupancy(aOcc)
  );

  pipe_stage_skid #(
    .DATA_W(64),
    .RD_W  (6)
  ) dutB (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (bInReady),
    .in_ctrl  (inCtrl),
    .in_data0 (inData0),
    .in_data1 (inData1),
    .in_rd    (inRd),
    .flush    (flush),
    .out_valid(bOutValid),
    .out_ready(outReady),
    .out_ctrl (bOutCtrl),
    .out_data0(bOutData0),
    .out_data1(bOutData1),
    .out_rd   (bOutRd),
    .occupancy(bOcc)
  );

  task automatic chkVal(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    int n;
    entT h;
    logic [1:0] ca, cb;
    n = q.size();
    if (n > 0) lastHead = q[0];
    h = lastHead;
    ca = 2'b00;
    cb = 2'b00;
    if (n > 0) begin
      ca = {h.ctrl[1], h.ctrl[0] && (h.rd[4:0] != 0)};
      cb = {h.ctrl[1], h.ctrl[0] && (h.rd != 0)};
    end
    chkVal("a_valid", 64'(aOutValid), 64'(n > 0));
    chkVal("a_occ", 64'(aOcc), 64'(n));
    chkVal("a_ready", 64'(aInReady), 64'(n < 2));
    chkVal("a_d0", 64'(aOutData0), 64'(h.d0[31:0]));
    chkVal("a_d1", 64'(aOutData1), 64'(h.d1[31:0]));
    chkVal("a_rd", 64'(aOutRd), 64'(h.rd[4:0]));
    chkVal("a_ctrl", 64'(aOutCtrl), 64'(ca));
    chkVal("b_valid", 64'(bOutValid), 64'(n > 0));
    chkVal("b_occ", 64'(bOcc), 64'(n));
    chkVal("b_ready", 64'(bInReady), 64'(n < 2));
    chkVal("b_d0", bOutData0, h.d0);
    chkVal("b_d1", bOutData1, h.d1);
    chkVal("b_rd", 64'(bOutRd), 64'(h.rd));
    chkVal("b_ctrl", 64'(bOutCtrl), 64'(cb));
  endtask

  // One falling edge: queue semantics of a 2-deep FIFO with flush.
  task automatic step();
    int n;
    bit acc, cons;
    entT e;
    n = q.size();
    acc = inValid && (n < 2);
    cons = (n > 0) && outReady;
    if (logOn && bOutValid && outReady) got.push_back(bOutData0);
    if (flush) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) begin
        e = '{inCtrl, inData0, inData1, inRd};
        q.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    checkModel();
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    #1;
    q.delete();
    lastHead = '0;
    checkModel();
    rst = 1'b0;
  endtask

  task automatic drive(
    input logic [63:0] d0,
    input logic [5:0]  rd
  );
    inValid = 1'b1;
    inData0 = d0;
    inData1 = ~d0;
    inRd    = rd;
  endtask

  initial begin
    rst      = 1'b0;
    inValid  = 1'b0;
    inCtrl   = 2'b11;
    inData0  = '0;
    inData1  = '0;
    inRd     = '0;
    flush    = 1'b0;
    outReady = 1'b0;
    lastHead = '0;
    #2;
    resetPulse();

    // Streaming
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(64'h10 + 64'(i), 6'(i + 1));
      step();
      chkVal("stream_d0", 64'(aOutData0), 64'h10 + 64'(i));
      chkVal("stream_occ", 64'(aOcc), 64'd1);
    end
    inValid = 1'b0;
    step();

    // Backpressure, full-width payload on the 64-bit instance
    outReady = 1'b0;
    drive(64'hFEDC_BA98_7654_00A0, 6'd33);
    step();
    drive(64'hFEDC_BA98_7654_00A1, 6'd34);
    step();
    chkVal("bp_occ", 64'(aOcc), 64'd2);
    chkVal("bp_ready", 64'(aInReady), 64'd0);
    drive(64'hFEDC_BA98_7654_00A2, 6'd35);
    step();
    chkVal("bp_hold", 64'(bOcc), 64'd2);
    logOn = 1;
    outReady = 1'b1;
    step();
    step();
    inValid = 1'b0;
    step();
    step();
    logOn = 0;
    chkVal("bp_cnt", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size())
        chkVal("bp_order", got[i],
               64'hFEDC_BA98_7654_00A0 + 64'(i));
    end

    // Flush while full with a new input pending
    outReady = 1'b0;
    drive(64'hC0, 6'd1);
    step();
    drive(64'hC1, 6'd2);
    step();
    drive(64'hB0, 6'd3);
    flush = 1'b1;
    step();
    chkVal("fl_occ", 64'(aOcc), 64'd0);
    chkVal("fl_valid", 64'(bOutValid), 64'd0);
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (3) begin
      step();
      chkVal("fl_gone", 64'(bOutValid), 64'd0);
    end

    // RegWrite gating on rd == 0
    outReady = 1'b0;
    inCtrl = 2'b01;
    drive(64'h55, 6'd0);
    step();
    chkVal("rd0_rw", 64'(aOutCtrl[0]), 64'd0);
    outReady = 1'b1;
    drive(64'h56, 6'd5);
    step();
    chkVal("rd5_rw", 64'(aOutCtrl[0]), 64'd1);
    chkVal("rd5_rwb", 64'(bOutCtrl[0]), 64'd1);
    inValid = 1'b0;
    step();

    // Reset in the middle of FULL
    outReady = 1'b0;
    inCtrl = 2'b11;
    drive(64'hD0, 6'd7);
    step();
    drive(64'hD1, 6'd8);
    step();
    rst = 1'b1;
    #1;
    chkVal("rst_valid", 64'(aOutValid), 64'd0);
    chkVal("rst_occ", 64'(bOcc), 64'd0);
    chkVal("rst_ready", 64'(aInReady), 64'd1);
    chkVal("rst_d0", bOutData0, 64'd0);
    chkVal("rst_ctrl", 64'(aOutCtrl), 64'd0);
    resetPulse();
    drive(64'hE0, 6'd9);
    step();
    chkVal("post_rst", 64'(aOutData0), 64'hE0);
    inValid = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      inValid  = ($urandom_range(3) != 0);
      outReady = ($urandom_range(2) != 0);
      flush    = ($urandom_range(15) == 0);
      inCtrl   = 2'($urandom);
      inData0  = {$urandom, $urandom};
      inData1  = {$urandom, $urandom};
      inRd     = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
      step();
      if ($urandom_range(63) == 0) resetPulse();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each data word (read data, address/ALU result).
REQ-002 SHALL have parameter RD_W, default 5, destination-register index width.
REQ-003 SHALL have parameter CTRL_W, default 2, write-back control bus width; bit 0 = RegWrite, bit 1 = MemtoReg.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on falling edge, as for every pipeline stage register.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream stage holds a valid instruction.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  write-back control.
REQ-009 SHALL have port in_data0 / in_data1  input  DATA_W each  memory read data / memory address (ALU result).
REQ-010 SHALL have port in_rd  input  RD_W  destination register.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have port out_valid  output  1  head entry valid.
REQ-013 SHALL have port out_ready  input  1  write-back consumes head this cycle.
REQ-014 SHALL have ports out_ctrl (CTRL_W), out_data0/out_data1 (DATA_W), out_rd (RD_W)  output  head-entry fields.
REQ-015 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-016 SHALL hold up to two entries: main (head) and skid.
REQ-017 Accept SHALL occur on a falling edge when in_valid && in_ready; consume when out_valid && out_ready.
REQ-018 in_ready SHALL be registered, equal to !skid_valid; no combinational path from out_ready to in_ready.
REQ-019 States SHALL be EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-020 EMPTY: accept -> ONE, entry loaded into main; out_ready ignored.
REQ-021 ONE: accept && consume -> ONE, main replaced by input; accept && !consume -> FULL, input to skid; consume only -> EMPTY; neither -> ONE, hold.
REQ-022 FULL: in_ready=0; consume -> ONE, skid moves to main; else hold.
REQ-023 Latency SHALL be one falling edge from accept to appearance at outputs when empty.
REQ-024 Entries SHALL leave in accept order; no entry duplicated or dropped except by flush.
REQ-025 flush SHALL dominate: next state EMPTY, concurrent accept discarded, concurrent consume still counted upstream as done.
REQ-026 out_ctrl[0] (RegWrite) SHALL be forced 0 when out_valid=0 or out_rd==0; other out_ctrl bits forced 0 when out_valid=0.
REQ-027 out_data0/out_data1/out_rd SHALL hold last head contents when out_valid=0 (don't-care but stable).
REQ-028 Widths SHALL pass through unchanged; no arithmetic on payload.

Reset
REQ-029 rst=1 SHALL immediately clear state to EMPTY, all payload registers to 0, out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
REQ-030 rst mid-operation SHALL discard both entries; first accept after release loads main.

Structure
REQ-031 Control-bit indices (REGWRITE_BIT=0, MEMTOREG_BIT=1) and the state encoding SHALL live in the shared pipeline package.
REQ-032 One sub-module natural: pipe_entry_reg, an enabled, async-reset payload register instantiated for main and skid.

Verification
REQ-033 Reset: rst pulse mid-FULL -> out_valid=0, occupancy=0, in_ready=1, all outputs 0 before next edge.
REQ-034 Streaming: in_valid=1, out_ready=1, data0=0x10,0x11,0x12 -> outputs 0x10,0x11,0x12 on successive edges, occupancy stays 1.
REQ-035 Backpressure: out_ready=0, accept 0xA0,0xA1 -> occupancy=2, in_ready=0, 0xA2 held upstream; out_ready=1 -> 0xA0,0xA1,0xA2 in order.
REQ-036 Flush in FULL with in_valid=1 (0xB0) -> next edge occupancy=0, out_valid=0, 0xB0 never appears.
REQ-037 rd gating: in_ctrl=2'b01, in_rd=0 -> out_ctrl[0]=0; same with in_rd=5 -> out_ctrl[0]=1.
REQ-038 Parameter sweep: DATA_W=64, RD_W=6 rerun REQ-035 -> identical ordering, full-width payload intact.
